br_issue_queue: RTL and testbench

In-order issue queue for the branch functional unit, sitting between dispatch/rename and `fu_br`. It buffers dispatched branch and jump micro-ops, captures missing source operands from the writeback broadcast, and issues the oldest entry once both operands are ready. Issue fields are registered and drive `fu_br` directly. The queue clears on a pipeline flush.

---
 rtl/br_issue_queue.sv | 207 ++++++++++++++++++++
 tb/tb_br_issue_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/br_issue_queue.sv
// In-order issue queue for the branch unit: buffers dispatched micro-ops, captures
// operands from the writeback broadcast and issues the head once both operands are ready.
`ifndef DATA_WIDTH_BR_OP
`define DATA_WIDTH_BR_OP 3
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ROB_DEPTH
`define ROB_DEPTH 16
`endif

package br_iq_pkg;
  localparam int TAG_W = $clog2(`ROB_DEPTH);

  typedef struct packed {
    logic                         valid;
    logic [`DATA_WIDTH_BR_OP-1:0] op;
    logic [`PC_WIDTH-1:0]         pc;
    logic [`WORD_WIDTH-1:0]       imm;
    logic [TAG_W-1:0]             pdst;
    logic                         rs1_ready;
    logic [`WORD_WIDTH-1:0]       rs1_value;
    logic [TAG_W-1:0]             rs1_rob;
    logic                         rs2_ready;
    logic [`WORD_WIDTH-1:0]       rs2_value;
    logic [TAG_W-1:0]             rs2_rob;
  } iq_entry_t;

  typedef struct packed {
    logic [`DATA_WIDTH_BR_OP-1:0] op;
    logic [`PC_WIDTH-1:0]         pc;
    logic [`WORD_WIDTH-1:0]       imm;
    logic [TAG_W-1:0]             pdst;
    logic [`WORD_WIDTH-1:0]       rs1_value;
    logic [`WORD_WIDTH-1:0]       rs2_value;
  } iq_issue_t;
endpackage

// One queue slot: holds the micro-op and snoops the writeback bus for its operands.
module br_iq_entry
  import br_iq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr,
  input  logic                   pop,
  input  iq_entry_t              din,
  input  logic                   wb_valid,
  input  logic [TAG_W-1:0]       wb_rob,
  input  logic [`WORD_WIDTH-1:0] wb_value,
  output logic                   rdy,
  output iq_issue_t              pay
);
  iq_entry_t st, nxt;

  function automatic iq_entry_t wake(input iq_entry_t e);
    wake = e;
    if (wb_valid && !e.rs1_ready && e.rs1_rob == wb_rob) begin
      wake.rs1_ready = 1'b1;
      wake.rs1_value = wb_value;
    end
    if (wb_valid && !e.rs2_ready && e.rs2_rob == wb_rob) begin
      wake.rs2_ready = 1'b1;
      wake.rs2_value = wb_value;
    end
  endfunction

  always_comb begin
    nxt = st;
    if (flush) begin
      nxt.valid     = 1'b0;
      nxt.rs1_ready = 1'b0;
      nxt.rs2_ready = 1'b0;
    end else if (wr) begin
      // same-cycle broadcast is captured on the way in
      nxt = wake(din);
    end else if (pop) begin
      nxt.valid = 1'b0;
    end else if (st.valid) begin
      nxt = wake(st);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= '0;
    else     st <= nxt;
  end

  assign rdy = st.valid && st.rs1_ready && st.rs2_ready;
  assign pay = '{op: st.op, pc: st.pc, imm: st.imm, pdst: st.pdst,
                 rs1_value: st.rs1_value, rs2_value: st.rs2_value};
endmodule

// DEPTH must be a power of two (>= 2) so the pointers wrap by plain overflow.
module br_issue_queue
  import br_iq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               br_dispatch_en,
  input  logic [`DATA_WIDTH_BR_OP-1:0]       br_dispatch_op,
  input  logic [`PC_WIDTH-1:0]               br_dispatch_pc,
  input  logic [`WORD_WIDTH-1:0]             br_dispatch_imm,
  input  logic                               br_dispatch_rs1_ready,
  input  logic                               br_dispatch_rs2_ready,
  input  logic [`WORD_WIDTH-1:0]             br_dispatch_rs1_value,
  input  logic [`WORD_WIDTH-1:0]             br_dispatch_rs2_value,
  input  logic [$clog2(`ROB_DEPTH)-1:0]      br_dispatch_rs1_rob,
  input  logic [$clog2(`ROB_DEPTH)-1:0]      br_dispatch_rs2_rob,
  input  logic [$clog2(`ROB_DEPTH)-1:0]      br_dispatch_Pdst,
  output logic                               br_queue_full,
  input  logic                               wb_valid,
  input  logic [$clog2(`ROB_DEPTH)-1:0]      wb_rob,
  input  logic [`WORD_WIDTH-1:0]             wb_value,
  output logic                               br_issue_en,
  output logic [`DATA_WIDTH_BR_OP-1:0]       br_issue_queue_op,
  output logic [`PC_WIDTH-1:0]               br_issue_queue_pc,
  output logic [`WORD_WIDTH-1:0]             br_issue_queue_imm,
  output logic [`WORD_WIDTH-1:0]             br_issue_queue_rs1_value,
  output logic [`WORD_WIDTH-1:0]             br_issue_queue_rs2_value,
  output logic [$clog2(`ROB_DEPTH)-1:0]      br_issue_queue_Pdst
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]              head, tail;
  logic [CW-1:0]              count, count_nxt;
  logic [DEPTH-1:0]           rdy;
  iq_issue_t [DEPTH-1:0]      pay;
  iq_issue_t                  iss;
  iq_entry_t                  din;
  logic                       do_disp, do_issue;

  // full is registered, so a same-cycle issue cannot make room for a dispatch
  assign do_disp  = br_dispatch_en && !br_queue_full;
  assign do_issue = (count != '0) && rdy[head];

  assign din = '{valid: 1'b1, op: br_dispatch_op, pc: br_dispatch_pc,
                 imm: br_dispatch_imm, pdst: br_dispatch_Pdst,
                 rs1_ready: br_dispatch_rs1_ready, rs1_value: br_dispatch_rs1_value,
                 rs1_rob: br_dispatch_rs1_rob,
                 rs2_ready: br_dispatch_rs2_ready, rs2_value: br_dispatch_rs2_value,
                 rs2_rob: br_dispatch_rs2_rob};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    br_iq_entry u_ent (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .wr       (do_disp && tail == AW'(i)),
      .pop      (do_issue && head == AW'(i)),
      .din      (din),
      .wb_valid (wb_valid),
      .wb_rob   (wb_rob),
      .wb_value (wb_value),
      .rdy      (rdy[i]),
      .pay      (pay[i])
    );
  end

  always_comb begin
    count_nxt = count;
    if (do_disp && !do_issue)      count_nxt = count + CW'(1);
    else if (!do_disp && do_issue) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      br_queue_full <= 1'b0;
      br_issue_en   <= 1'b0;
      iss           <= '0;
    end else if (flush) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      br_queue_full <= 1'b0;
      br_issue_en   <= 1'b0;
    end else begin
      if (do_issue) begin
        head <= head + AW'(1);
        iss  <= pay[head];
      end
      if (do_disp) tail <= tail + AW'(1);
      count         <= count_nxt;
      br_queue_full <= (count_nxt == CW'(DEPTH));
      br_issue_en   <= do_issue;
    end
  end

  assign br_issue_queue_op        = iss.op;
  assign br_issue_queue_pc        = iss.pc;
  assign br_issue_queue_imm       = iss.imm;
  assign br_issue_queue_rs1_value = iss.rs1_value;
  assign br_issue_queue_rs2_value = iss.rs2_value;
  assign br_issue_queue_Pdst      = iss.pdst;
endmodule

// File: tb/tb_br_issue_queue.sv
// Bench for br_issue_queue: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
`ifndef DATA_WIDTH_BR_OP
`define DATA_WIDTH_BR_OP 3
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ROB_DEPTH
`define ROB_DEPTH 16
`endif

module tb_br_issue_queue;
  localparam int DEPTH = 4;
  localparam int OW = `DATA_WIDTH_BR_OP;
  localparam int PW = `PC_WIDTH;
  localparam int WW = `WORD_WIDTH;
  localparam int TW = $clog2(`ROB_DEPTH);

  logic clk = 1'b0;
  logic rst, flush, den, r1, r2, full, wbv, en;
  logic [OW-1:0] op, i_op;
  logic [PW-1:0] pc, i_pc;
  logic [WW-1:0] imm, v1, v2, wbval, i_imm, i_v1, i_v2;
  logic [TW-1:0] t1, t2, pdst, wbrob, i_pdst;

  always #5 clk = ~clk;

  br_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .br_dispatch_en(den), .br_dispatch_op(op), .br_dispatch_pc(pc), .br_dispatch_imm(imm),
    .br_dispatch_rs1_ready(r1), .br_dispatch_rs2_ready(r2),
    .br_dispatch_rs1_value(v1), .br_dispatch_rs2_value(v2),
    .br_dispatch_rs1_rob(t1), .br_dispatch_rs2_rob(t2), .br_dispatch_Pdst(pdst),
    .br_queue_full(full), .wb_valid(wbv), .wb_rob(wbrob), .wb_value(wbval),
    .br_issue_en(en), .br_issue_queue_op(i_op), .br_issue_queue_pc(i_pc),
    .br_issue_queue_imm(i_imm), .br_issue_queue_rs1_value(i_v1),
    .br_issue_queue_rs2_value(i_v2), .br_issue_queue_Pdst(i_pdst)
  );

  typedef struct {
    logic [OW-1:0] op;
    logic [PW-1:0] pc;
    logic [WW-1:0] imm;
    logic [TW-1:0] pdst;
    logic          r1, r2;
    logic [WW-1:0] v1, v2;
    logic [TW-1:0] t1, t2;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t m_iss;
  logic   m_en, m_full;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    m_en = 1'b0; m_full = 1'b0;
    m_iss.op = '0; m_iss.pc = '0; m_iss.imm = '0; m_iss.pdst = '0;
    m_iss.r1 = 1'b0; m_iss.r2 = 1'b0; m_iss.v1 = '0; m_iss.v2 = '0;
    m_iss.t1 = '0; m_iss.t2 = '0;
  endtask

  // One clock of the behavioural queue, using the inputs currently driven.
  task automatic model_step();
    m_ent_t e;
    bit iss;
    if (flush) begin
      mq.delete();
      m_en = 1'b0; m_full = 1'b0;
      return;
    end
    iss = (mq.size() > 0) && mq[0].r1 && mq[0].r2;
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (wbv && !e.r1 && e.t1 == wbrob) begin e.r1 = 1'b1; e.v1 = wbval; end
      if (wbv && !e.r2 && e.t2 == wbrob) begin e.r2 = 1'b1; e.v2 = wbval; end
      mq[i] = e;
    end
    if (iss) m_iss = mq.pop_front();
    m_en = iss;
    if (den && !m_full) begin
      e.op = op; e.pc = pc; e.imm = imm; e.pdst = pdst;
      e.r1 = r1; e.v1 = v1; e.t1 = t1; e.r2 = r2; e.v2 = v2; e.t2 = t2;
      if (wbv && !e.r1 && e.t1 == wbrob) begin e.r1 = 1'b1; e.v1 = wbval; end
      if (wbv && !e.r2 && e.t2 == wbrob) begin e.r2 = 1'b1; e.v2 = wbval; end
      mq.push_back(e);
    end
    m_full = (mq.size() == DEPTH);
  endtask

  task automatic check_outs();
    chk("issue_en", 64'(en), 64'(m_en));
    chk("full", 64'(full), 64'(m_full));
    chk("op", 64'(i_op), 64'(m_iss.op));
    chk("pc", 64'(i_pc), 64'(m_iss.pc));
    chk("imm", 64'(i_imm), 64'(m_iss.imm));
    chk("rs1_value", 64'(i_v1), 64'(m_iss.v1));
    chk("rs2_value", 64'(i_v2), 64'(m_iss.v2));
    chk("pdst", 64'(i_pdst), 64'(m_iss.pdst));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle();
    den = 1'b0; wbv = 1'b0; flush = 1'b0;
  endtask

  task automatic disp(input logic [OW-1:0] o, input logic [PW-1:0] p, input logic [WW-1:0] im,
                      input logic rd1, input logic [WW-1:0] val1, input logic [TW-1:0] tg1,
                      input logic rd2, input logic [WW-1:0] val2, input logic [TW-1:0] tg2,
                      input logic [TW-1:0] pd);
    den = 1'b1; op = o; pc = p; imm = im;
    r1 = rd1; v1 = val1; t1 = tg1; r2 = rd2; v2 = val2; t2 = tg2; pdst = pd;
  endtask

  task automatic wb(input logic [TW-1:0] tg, input logic [WW-1:0] val);
    wbv = 1'b1; wbrob = tg; wbval = val;
  endtask

  initial begin
    rst = 1'b1; idle();
    op = '0; pc = '0; imm = '0; r1 = 0; r2 = 0; v1 = '0; v2 = '0;
    t1 = '0; t2 = '0; pdst = '0; wbrob = '0; wbval = '0;
    reset_model();
    repeat (2) @(negedge clk);
    check_outs();
    rst = 1'b0;

    // ready dispatch: issue two edges after dispatch
    disp(3'd0, 32'h100, 32'h20, 1, 32'd5, 4'd0, 1, 32'd5, 4'd0, 4'd3);
    cycle(); chk("d1_no_early", 64'(en), 64'd0);
    idle(); cycle();
    chk("d1_en", 64'(en), 64'd1); chk("d1_pc", 64'(i_pc), 64'h100);
    chk("d1_imm", 64'(i_imm), 64'h20); chk("d1_rs1", 64'(i_v1), 64'd5);
    chk("d1_rs2", 64'(i_v2), 64'd5); chk("d1_pdst", 64'(i_pdst), 64'd3);
    cycle(); chk("d1_pulse", 64'(en), 64'd0);

    // wakeup after idle cycles
    disp(3'd1, 32'h200, 32'h8, 0, 32'd0, 4'd7, 1, 32'd1, 4'd0, 4'd4);
    cycle(); idle();
    repeat (3) begin cycle(); chk("d2_wait", 64'(en), 64'd0); end
    wb(4'd7, 32'd9); cycle(); chk("d2_wait_wb", 64'(en), 64'd0);
    idle(); cycle();
    chk("d2_en", 64'(en), 64'd1); chk("d2_rs1", 64'(i_v1), 64'd9);
    cycle();

    // in-order hold: B ready but behind waiting A
    disp(3'd2, 32'h300, 32'h4, 0, 32'd0, 4'd2, 1, 32'd7, 4'd0, 4'd8);
    cycle();
    disp(3'd3, 32'h304, 32'h4, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0, 4'd9);
    cycle(); idle();
    repeat (2) begin cycle(); chk("d3_hold", 64'(en), 64'd0); end
    wb(4'd2, 32'h44); cycle(); idle();
    cycle(); chk("d3_a_pdst", 64'(i_pdst), 64'd8);
    cycle(); chk("d3_b_pdst", 64'(i_pdst), 64'd9);
    cycle();

    // same-cycle capture at dispatch
    disp(3'd2, 32'h400, 32'h4, 0, 32'd0, 4'd2, 1, 32'd7, 4'd0, 4'd10);
    wb(4'd2, 32'h33); cycle(); wbv = 1'b0;
    disp(3'd3, 32'h404, 32'h4, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0, 4'd11);
    cycle(); idle();
    chk("d4_a_en", 64'(en), 64'd1); chk("d4_a_rs1", 64'(i_v1), 64'h33);
    cycle(); chk("d4_b_pdst", 64'(i_pdst), 64'd11); chk("d4_b_en", 64'(en), 64'd1);
    cycle();

    // full: four waiting on tag 6, fifth dispatch ignored
    for (int k = 0; k < DEPTH; k++) begin
      disp(3'd4, 32'h500 + 32'(4*k), 32'h10, 0, 32'd0, 4'd6, 1, 32'd3, 4'd0, 4'(k));
      cycle();
    end
    chk("d5_full", 64'(full), 64'd1);
    disp(3'd5, 32'h5f0, 32'h10, 1, 32'd0, 4'd0, 1, 32'd0, 4'd0, 4'd15);
    cycle(); idle(); chk("d5_still_full", 64'(full), 64'd1);
    wb(4'd6, 32'h66); cycle(); idle();
    cycle(); chk("d5_full_fall", 64'(full), 64'd0); chk("d5_i0", 64'(i_pdst), 64'd0);
    for (int k = 1; k < DEPTH; k++) begin
      cycle(); chk("d5_b2b_en", 64'(en), 64'd1); chk("d5_order", 64'(i_pdst), 64'(k));
    end
    cycle(); chk("d5_drained", 64'(en), 64'd0);

    // flush on the cycle the first issue is due
    for (int k = 0; k < 3; k++) begin
      disp(3'd0, 32'h600 + 32'(4*k), 32'h0, 0, 32'd0, 4'd1, 1, 32'd0, 4'd0, 4'(k + 4));
      cycle();
    end
    idle(); wb(4'd1, 32'h11); cycle();
    idle(); flush = 1'b1; cycle(); flush = 1'b0;
    chk("d6_no_issue", 64'(en), 64'd0); chk("d6_full", 64'(full), 64'd0);
    cycle(); chk("d6_empty", 64'(en), 64'd0);
    disp(3'd1, 32'h700, 32'h4, 1, 32'd2, 4'd0, 1, 32'd2, 4'd0, 4'd12);
    cycle(); idle(); cycle(); chk("d6_after", 64'(i_pc), 64'h700);
    cycle();

    // async reset while issuing
    disp(3'd1, 32'h800, 32'h4, 1, 32'd2, 4'd0, 1, 32'd3, 4'd0, 4'd13);
    cycle(); idle(); cycle(); chk("d7_pre", 64'(en), 64'd1);
    #1 rst = 1'b1;
    #1 chk("d7_en", 64'(en), 64'd0); chk("d7_pc", 64'(i_pc), 64'd0);
    chk("d7_pdst", 64'(i_pdst), 64'd0); chk("d7_rs2", 64'(i_v2), 64'd0);
    @(negedge clk); rst = 1'b0; reset_model();
    check_outs();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      den   = ($urandom_range(0, 9) < 6);
      op    = OW'($urandom); pc = $urandom; imm = $urandom; pdst = TW'($urandom);
      r1    = $urandom_range(0, 1); r2 = $urandom_range(0, 1);
      v1    = $urandom; v2 = $urandom;
      t1    = TW'($urandom_range(0, 3)); t2 = TW'($urandom_range(0, 3));
      wbv   = ($urandom_range(0, 9) < 4);
      wbrob = TW'($urandom_range(0, 3)); wbval = $urandom;
      flush = ($urandom_range(0, 99) < 3);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
